// File: rtl/ip_tx_deframer.sv
// ip_tx_deframer: turns the TX byte FIFO stream into an IP TX header plus a payload AXI-Stream.
// A 13-byte descriptor (dest, src, proto, ttl, total length, dscp/ecn) precedes each payload.
// Malformed descriptors are consumed and dropped, so the stream stays aligned.
// Build option IP_TX_DEFRAMER_STATS_EN: when defined, saturating frame/drop counters are implemented.
// When it is undefined, frame_count and drop_count are tied to zero.
module ip_tx_deframer #(
    parameter int MAX_IP_LEN = 1500,
    parameter int IP_HDR_LEN = 20
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [7:0]   din_dout,
    input  logic         din_empty,
    output logic         din_rd_en,
    output logic         tx_hdr_valid,
    input  logic         tx_hdr_ready,
    output logic [103:0] tx_hdr,
    output logic [7:0]   tx_payload_tdata,
    output logic         tx_payload_tvalid,
    input  logic         tx_payload_tready,
    output logic         tx_payload_tlast,
    output logic         busy,
    output logic [15:0]  frame_count,
    output logic [15:0]  drop_count
);
    localparam logic [15:0] MAX_LEN = 16'(MAX_IP_LEN);
    localparam logic [15:0] HDR_LEN = 16'(IP_HDR_LEN);

    typedef enum logic [1:0] {S_HDR, S_HDR_OUT, S_PAYLOAD, S_DISCARD} state_t;

    state_t        state_q, state_d;
    logic [3:0]    idx_q, idx_d;
    logic [15:0]   rem_q, rem_d;
    logic [103:0]  hdr_q, hdr_d;
    logic          hdr_valid_q, hdr_valid_d;
    logic [15:0]   len;
    logic          tvalid, xfer, last, pop;
    logic          frame_done, desc_drop;

    // Total length already sits in the header register once bytes 10-11 are in.
    assign len = hdr_q[23:8];

    // FIFO-side handshakes follow the FWFT empty flag directly; reset forces them low at once.
    always_comb begin
        tvalid = ~rst & (state_q == S_PAYLOAD) & ~din_empty;
        xfer   = tvalid & tx_payload_tready;
        last   = (state_q == S_PAYLOAD) & (rem_q == 16'd1);
        pop    = xfer | (~rst & ~din_empty & ((state_q == S_HDR) | (state_q == S_DISCARD)));
    end

    // Next-state: descriptor collection, header handoff, payload count-down, discard.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        rem_d      = rem_q;
        hdr_d      = hdr_q;
        frame_done = 1'b0;
        desc_drop  = 1'b0;
        case (state_q)
            S_HDR: begin
                if (pop) begin
                    if (idx_q == 4'd12) begin
                        // last descriptor byte is {dscp, ecn}; header port wants {ecn, dscp}
                        hdr_d[7:0] = {din_dout[1:0], din_dout[7:2]};
                        idx_d      = 4'd0;
                        if (len > MAX_LEN) begin
                            state_d = S_DISCARD;
                            rem_d   = len - HDR_LEN;
                        end else if (len > HDR_LEN) begin
                            state_d = S_HDR_OUT;
                        end else begin
                            desc_drop = 1'b1;
                        end
                    end else begin
                        for (int b = 0; b < 12; b++) begin
                            if (idx_q == 4'(b)) hdr_d[103 - 8*b -: 8] = din_dout;
                        end
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
            S_HDR_OUT: begin
                if (tx_hdr_ready) begin
                    rem_d   = len - HDR_LEN;
                    state_d = S_PAYLOAD;
                end
            end
            S_PAYLOAD: begin
                if (xfer) begin
                    rem_d = rem_q - 16'd1;
                    if (last) begin
                        state_d    = S_HDR;
                        frame_done = 1'b1;
                    end
                end
            end
            S_DISCARD: begin
                if (pop) begin
                    rem_d = rem_q - 16'd1;
                    if (rem_q == 16'd1) begin
                        state_d   = S_HDR;
                        desc_drop = 1'b1;
                    end
                end
            end
            default: state_d = S_HDR;
        endcase
        hdr_valid_d = (state_d == S_HDR_OUT);
    end

    // FSM and datapath registers; reset abandons any frame in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_HDR;
            idx_q       <= 4'd0;
            rem_q       <= 16'd0;
            hdr_q       <= '0;
            hdr_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            rem_q       <= rem_d;
            hdr_q       <= hdr_d;
            hdr_valid_q <= hdr_valid_d;
        end
    end

    assign din_rd_en         = pop;
    assign tx_hdr_valid      = hdr_valid_q;
    assign tx_hdr            = hdr_q;
    assign tx_payload_tvalid = tvalid;
    assign tx_payload_tdata  = tvalid ? din_dout : 8'd0;
    assign tx_payload_tlast  = last;
    assign busy              = ~((state_q == S_HDR) & (idx_q == 4'd0));

`ifdef IP_TX_DEFRAMER_STATS_EN
    logic [15:0] frame_cnt_q, frame_cnt_d, drop_cnt_q, drop_cnt_d;

    // Saturating event counters
    always_comb begin
        frame_cnt_d = frame_cnt_q;
        drop_cnt_d  = drop_cnt_q;
        if (frame_done && frame_cnt_q != 16'hFFFF) frame_cnt_d = frame_cnt_q + 16'd1;
        if (desc_drop && drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
    end

    // Counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cnt_q <= 16'd0;
            drop_cnt_q  <= 16'd0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    assign frame_count = frame_cnt_q;
    assign drop_count  = drop_cnt_q;
`else
    logic unused_stats;
    assign unused_stats = frame_done ^ desc_drop;
    assign frame_count  = 16'd0;
    assign drop_count   = 16'd0;
`endif

endmodule
